// File: rtl/bin_add_kx2_acc.sv
// bin_add_kx2_acc: NUM_OPS gated operands plus an LSB carry summed through a pipelined adder tree, with accumulate mode and a sticky overflow flag.
// Optional macro BIN_ADD_SATURATE_EN: accumulation saturates at all-ones instead of wrapping modulo 2^ACC_WIDTH.
module bin_add_kx2_acc #(
  parameter int OP_WIDTH    = 16,
  parameter int NUM_OPS     = 4,
  parameter int CARRY_WIDTH = 1,
  parameter int ACC_WIDTH   = 24
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [CARRY_WIDTH-1:0]          in_carry,
  input  logic [NUM_OPS*OP_WIDTH-1:0]     in_ops,
  input  logic [NUM_OPS-1:0]              op_enable,
  input  logic                            acc_mode,
  input  logic                            acc_clear,
  output logic                            out_valid,
  output logic [OP_WIDTH-1:0]             low_sum,
  output logic [ACC_WIDTH-OP_WIDTH-1:0]   hi_sum,
  output logic                            overflow
);

  localparam int NUM_PAIRS = (NUM_OPS + 1) / 2;
  localparam int PAIR_W    = OP_WIDTH + 1;

  generate
    if (NUM_OPS < 2 || NUM_OPS > 16) begin : g_bad_num_ops
      $error("bin_add_kx2_acc: NUM_OPS must be in 2..16");
    end
    if (ACC_WIDTH < OP_WIDTH + $clog2(NUM_OPS) + 1) begin : g_bad_acc_width
      $error("bin_add_kx2_acc: ACC_WIDTH must be >= OP_WIDTH+clog2(NUM_OPS)+1");
    end
  endgenerate

  // S1: operand gating and sideband capture
  logic [NUM_OPS-1:0][OP_WIDTH-1:0] ops_masked;
  logic [NUM_OPS-1:0][OP_WIDTH-1:0] s1_ops_q;
  logic [CARRY_WIDTH-1:0]           s1_carry_q;
  logic                             s1_valid_q, s1_mode_q, s1_clear_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_mask
      assign ops_masked[gi] = op_enable[gi] ? in_ops[gi*OP_WIDTH +: OP_WIDTH] : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_ops_q   <= '0;
      s1_carry_q <= '0;
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_clear_q <= 1'b0;
    end else begin
      s1_ops_q   <= ops_masked;
      s1_carry_q <= in_carry;
      s1_valid_q <= in_valid;
      s1_mode_q  <= acc_mode;
      s1_clear_q <= acc_clear;
    end
  end

  // First tree level: pairwise sums registered so the final add stays short for wide NUM_OPS
  logic [NUM_PAIRS-1:0][PAIR_W-1:0] pair_d;
  logic [NUM_PAIRS-1:0][PAIR_W-1:0] s2p_pair_q;
  logic [CARRY_WIDTH-1:0]           s2p_carry_q;
  logic                             s2p_valid_q, s2p_mode_q, s2p_clear_q;

  generate
    for (gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
      if (2*gi + 1 < NUM_OPS) begin : g_two
        assign pair_d[gi] = {1'b0, s1_ops_q[2*gi]} + {1'b0, s1_ops_q[2*gi+1]};
      end else begin : g_one
        assign pair_d[gi] = {1'b0, s1_ops_q[2*gi]};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      s2p_pair_q  <= '0;
      s2p_carry_q <= '0;
      s2p_valid_q <= 1'b0;
      s2p_mode_q  <= 1'b0;
      s2p_clear_q <= 1'b0;
    end else begin
      s2p_pair_q  <= pair_d;
      s2p_carry_q <= s1_carry_q;
      s2p_valid_q <= s1_valid_q;
      s2p_mode_q  <= s1_mode_q;
      s2p_clear_q <= s1_clear_q;
    end
  end

  // S2: full-width tree sum; width rule guarantees no carry-out here
  logic [ACC_WIDTH-1:0] sum_d;
  logic [ACC_WIDTH-1:0] s2_sum_q;
  logic                 s2_valid_q, s2_mode_q, s2_clear_q;

  always_comb begin
    sum_d = ACC_WIDTH'(s2p_carry_q);
    for (int k = 0; k < NUM_PAIRS; k++) begin
      sum_d = sum_d + ACC_WIDTH'(s2p_pair_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_clear_q <= 1'b0;
    end else begin
      s2_sum_q   <= sum_d;
      s2_valid_q <= s2p_valid_q;
      s2_mode_q  <= s2p_mode_q;
      s2_clear_q <= s2p_clear_q;
    end
  end

  // S3: accumulator, sticky overflow and held result
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] res_q, res_d;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH:0]   acc_ext;
  logic                 overflow_q, overflow_d;
  logic                 out_valid_q;

  always_comb begin
    acc_base   = s2_clear_q ? '0 : acc_q;
    acc_ext    = {1'b0, acc_base} + {1'b0, s2_sum_q};
    acc_d      = acc_q;
    overflow_d = overflow_q;
    res_d      = res_q;
    // A clear applies even on bubbles; the beat's own carry-out may re-set overflow below
    if (s2_clear_q) begin
      acc_d      = '0;
      overflow_d = 1'b0;
    end
    if (s2_valid_q) begin
      if (s2_mode_q) begin
`ifdef BIN_ADD_SATURATE_EN
        acc_d = acc_ext[ACC_WIDTH] ? '1 : acc_ext[ACC_WIDTH-1:0];
`else
        acc_d = acc_ext[ACC_WIDTH-1:0];
`endif
        overflow_d = overflow_d | acc_ext[ACC_WIDTH];
        res_d      = acc_d;
      end else begin
        res_d = s2_sum_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      res_q       <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      res_q       <= res_d;
      overflow_q  <= overflow_d;
      out_valid_q <= s2_valid_q;
    end
  end

  assign out_valid = out_valid_q;
  assign low_sum   = res_q[OP_WIDTH-1:0];
  assign hi_sum    = res_q[ACC_WIDTH-1:OP_WIDTH];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bin_add_kx2_acc.sv
// Self-checking bench for bin_add_kx2_acc: directed beats with a cycle-stamped expected-result queue.
module tb_bin_add_kx2_acc;
  localparam int OPW  = 16;
  localparam int NOPS = 4;
  localparam int CW   = 1;
  localparam int AW   = 24;
  localparam int HW   = AW - OPW;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [CW-1:0]        in_carry;
  logic [NOPS*OPW-1:0]  in_ops;
  logic [NOPS-1:0]      op_enable;
  logic                 acc_mode;
  logic                 acc_clear;
  logic                 out_valid;
  logic [OPW-1:0]       low_sum;
  logic [HW-1:0]        hi_sum;
  logic                 overflow;

  always #5 clk = ~clk;

  bin_add_kx2_acc #(
    .OP_WIDTH(OPW), .NUM_OPS(NOPS), .CARRY_WIDTH(CW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_carry(in_carry),
    .in_ops(in_ops), .op_enable(op_enable), .acc_mode(acc_mode),
    .acc_clear(acc_clear), .out_valid(out_valid), .low_sum(low_sum),
    .hi_sum(hi_sum), .overflow(overflow)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [OPW-1:0] lo;
    logic [HW-1:0]  hi;
    logic           ovf;
  } exp_t;

  exp_t           sbq[$];
  int             n_tests = 0;
  int             n_fail  = 0;
  logic [AW-1:0]  m_acc   = '0;
  logic           m_ovf   = 1'b0;
  logic [OPW-1:0] last_lo = '0;
  logic [HW-1:0]  last_hi = '0;

  function automatic logic [AW-1:0] ref_sum(input logic [NOPS*OPW-1:0] ops,
                                            input logic [NOPS-1:0] en,
                                            input logic [CW-1:0] c);
    logic [AW-1:0] s;
    s = AW'(c);
    for (int k = 0; k < NOPS; k++) begin
      if (en[k]) s = s + AW'(ops[k*OPW +: OPW]);
    end
    return s;
  endfunction

  // Drive one beat at the falling edge and push its expected result, due 4 falling edges later.
  task automatic drive(input logic v, input logic [NOPS*OPW-1:0] ops,
                       input logic [NOPS-1:0] en, input logic [CW-1:0] c,
                       input logic mode, input logic clr);
    logic [AW-1:0] s, base, res;
    logic [AW:0]   ext;
    exp_t          e;
    @(negedge clk);
    in_valid  = v;
    in_ops    = ops;
    op_enable = en;
    in_carry  = c;
    acc_mode  = mode;
    acc_clear = clr;
    s    = ref_sum(ops, en, c);
    base = clr ? '0 : m_acc;
    if (clr) begin
      m_acc = '0;
      m_ovf = 1'b0;
    end
    res = s;
    if (v && mode) begin
      ext   = {1'b0, base} + {1'b0, s};
      m_ovf = m_ovf | ext[AW];
`ifdef BIN_ADD_SATURATE_EN
      m_acc = ext[AW] ? '1 : ext[AW-1:0];
`else
      m_acc = ext[AW-1:0];
`endif
      res = m_acc;
    end
    if (v) begin
      e.cyc = cyc + 4;
      e.lo  = res[OPW-1:0];
      e.hi  = res[AW-1:OPW];
      e.ovf = m_ovf;
      sbq.push_back(e);
    end
  endtask

  // Pin the most recently queued expectation to a literal value.
  task automatic set_last(input logic [OPW-1:0] lo, input logic [HW-1:0] hi, input logic ovf);
    exp_t e;
    e     = sbq.pop_back();
    e.lo  = lo;
    e.hi  = hi;
    e.ovf = ovf;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      acc_mode  = 1'b0;
      acc_clear = 1'b0;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_lo = '0;
        last_hi = '0;
      end else if (out_valid) begin
        n_tests++;
        assert (sbq.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_out_valid cyc=%0d observed lo=%h hi=%h expected no output", cyc, low_sum, hi_sum);
        end
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          n_tests++;
          assert (cyc === e.cyc && low_sum === e.lo && hi_sum === e.hi && overflow === e.ovf) else begin
            n_fail++;
            $error("FAIL result observed cyc=%0d lo=%h hi=%h ovf=%b expected cyc=%0d lo=%h hi=%h ovf=%b",
                   cyc, low_sum, hi_sum, overflow, e.cyc, e.lo, e.hi, e.ovf);
          end
          last_lo = e.lo;
          last_hi = e.hi;
        end
      end else begin
        n_tests++;
        assert (low_sum === last_lo && hi_sum === last_hi) else begin
          n_fail++;
          $error("FAIL hold cyc=%0d observed lo=%h hi=%h expected lo=%h hi=%h", cyc, low_sum, hi_sum, last_lo, last_hi);
        end
        if (sbq.size() > 0) begin
          n_tests++;
          assert (sbq[0].cyc > cyc) else begin
            n_fail++;
            $error("FAIL missing_out_valid cyc=%0d observed out_valid=0 expected 1 (due cyc=%0d)", cyc, sbq[0].cyc);
            e = sbq.pop_front();
          end
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_carry  = '0;
    in_ops    = '0;
    op_enable = '0;
    acc_mode  = 1'b0;
    acc_clear = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    n_tests++;
    assert ({out_valid, overflow, low_sum, hi_sum} === '0) else begin
      n_fail++;
      $error("FAIL reset_state observed v=%b ovf=%b lo=%h hi=%h expected all 0", out_valid, overflow, low_sum, hi_sum);
    end
    @(negedge clk);
    reset = 1'b0;

    // Plain sums, back to back
    drive(1'b1, {16'hffff, 16'h0001, 16'hdfea, 16'h3f4e}, 4'b1111, 1'b1, 1'b0, 1'b0);
    set_last(16'h1f39, 8'h02, 1'b0);
    drive(1'b1, {16'hffff, 16'h0001, 16'hdfea, 16'h3f4e}, 4'b0101, 1'b1, 1'b0, 1'b0);
    set_last(16'h3f50, 8'h00, 1'b0);
    drive(1'b1, {16'hffff, 16'h0001, 16'hdfea, 16'h3f4e}, 4'b0000, 1'b0, 1'b0, 1'b0);
    set_last(16'h0000, 8'h00, 1'b0);
    idle(6);

    // Accumulate 65 beats of 4 x 0xffff, first beat clears
    for (int b = 1; b <= 65; b++) begin
      drive(1'b1, {4{16'hffff}}, 4'b1111, 1'b0, 1'b1, (b == 1));
      if (b == 64) set_last(16'hff00, 8'hff, 1'b0);
`ifdef BIN_ADD_SATURATE_EN
      if (b == 65) set_last(16'hffff, 8'hff, 1'b1);
`else
      if (b == 65) set_last(16'hfefc, 8'h03, 1'b1);
`endif
    end
    // Clearing bubble: no output pulse, overflow drops
    drive(1'b0, '0, 4'b0000, 1'b0, 1'b0, 1'b1);
    idle(4);
    n_tests++;
    assert (overflow === 1'b0) else begin
      n_fail++;
      $error("FAIL bubble_clear_overflow observed %b expected 0", overflow);
    end

    // Leave a nonzero accumulator so the post-reset check is meaningful
    drive(1'b1, {16'd1, 16'd2, 16'd3, 16'd4}, 4'b1111, 1'b1, 1'b1, 1'b0);
    idle(5);

    // Streaming plain sums, one beat per cycle
    for (int i = 'h3dfe; i <= 'hfffe; i++) begin
      drive(1'b1, {16'(i + 1), 16'(i * 3), 16'(i), ~16'(i)}, 4'b1111, 1'(i % 2), 1'b0, 1'b0);
    end

    // Reset with beats in flight
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    sbq.delete();
    m_acc = '0;
    m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      assert ({out_valid, overflow, low_sum, hi_sum} === '0) else begin
        n_fail++;
        $error("FAIL post_reset_%0d observed v=%b ovf=%b lo=%h hi=%h expected all 0", k, out_valid, overflow, low_sum, hi_sum);
      end
    end
    drive(1'b1, {16'd5, 16'd6, 16'd7, 16'd8}, 4'b1111, 1'b0, 1'b1, 1'b0);
    set_last(16'h001a, 8'h00, 1'b0);
    idle(6);

    n_tests++;
    assert (sbq.size() == 0) else begin
      n_fail++;
      $error("FAIL drain observed %0d pending expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
